// File: rtl/symbol_framer_if.sv
// symbol_framer_if: handshake, symbol and receive signals between the framer and its
// CRC/FSK neighbours. The master side is the CRC generator/checker and modem; the slave
// side is the framer.
interface symbol_framer_if #(
   parameter int unsigned SPS          = 256,
   parameter int unsigned FRAME_BITS   = 16,
   parameter int unsigned BITS_PER_SYM = 1
);
   localparam int unsigned NSYM = FRAME_BITS / BITS_PER_SYM;
   localparam int unsigned PW   = $clog2(SPS);
   localparam int unsigned SW   = (NSYM > 1) ? $clog2(NSYM) : 1;

   logic [FRAME_BITS-1:0]   tx_data;
   logic                    tx_valid;
   logic                    tx_ready;
   logic                    abort;
   logic [BITS_PER_SYM-1:0] tx_sym;
   logic                    busy;
   logic                    sym_strobe;
   logic [PW-1:0]           phase;
   logic [SW-1:0]           sym_idx;
   logic [BITS_PER_SYM-1:0] rx_sym;
   logic [FRAME_BITS-1:0]   rx_data;
   logic                    rx_valid;

   modport master (
      output tx_data, tx_valid, abort, rx_sym,
      input  tx_ready, tx_sym, busy, sym_strobe, phase, sym_idx, rx_data, rx_valid
   );

   modport slave (
      input  tx_data, tx_valid, abort, rx_sym,
      output tx_ready, tx_sym, busy, sym_strobe, phase, sym_idx, rx_data, rx_valid
   );
endinterface

// File: rtl/symbol_framer.sv
// symbol_framer: per-symbol phase/index timing, LSB-first symbol serializer and a
// mid-symbol sampling deserializer for the CRC/FSK link.
// Optional feature macro: SYMBOL_FRAMER_LOOPBACK_EN adds i_loopback, which feeds the
// transmitted symbol back into the receive path instead of rx_sym.
module symbol_framer #(
   parameter int unsigned SPS          = 256,
   parameter int unsigned FRAME_BITS   = 16,
   parameter int unsigned BITS_PER_SYM = 1
) (
   input logic            i_clk_sys,
   input logic            i_reset,
`ifdef SYMBOL_FRAMER_LOOPBACK_EN
   input logic            i_loopback,
`endif
   symbol_framer_if.slave bus
);
   localparam int unsigned NSYM = FRAME_BITS / BITS_PER_SYM;
   localparam int unsigned PW   = $clog2(SPS);
   localparam int unsigned SW   = (NSYM > 1) ? $clog2(NSYM) : 1;

   localparam logic [PW-1:0] PhLast  = PW'(SPS - 1);
   localparam logic [PW-1:0] PhMid   = PW'(SPS / 2);
   localparam logic [SW-1:0] IdxLast = SW'(NSYM - 1);

   typedef enum logic {StIdle, StRun} state_t;

   state_t                  r_state, w_state_d;
   logic [PW-1:0]           r_phase, w_phase_d;
   logic [SW-1:0]           r_sym_idx, w_sym_idx_d;
   logic [FRAME_BITS-1:0]   r_shift, w_shift_d;
   logic [FRAME_BITS-1:0]   r_rx_asm, w_rx_asm_d;
   logic [FRAME_BITS-1:0]   r_rx_data, w_rx_data_d;
   logic                    r_rx_valid, w_rx_valid_d;
   // Low from reset until the first edge after release, so tx_ready is never 1 in reset.
   logic                    r_rst_done;

   logic                    w_run;
   logic                    w_frame_end;
   logic                    w_abort;
   logic                    w_handshake;
   logic                    w_sample;
   logic [BITS_PER_SYM-1:0] w_rx_in;

`ifdef SYMBOL_FRAMER_LOOPBACK_EN
   assign w_rx_in = i_loopback ? r_shift[BITS_PER_SYM-1:0] : bus.rx_sym;
`else
   assign w_rx_in = bus.rx_sym;
`endif

   assign w_run       = (r_state == StRun);
   assign w_frame_end = w_run && (r_phase == PhLast) && (r_sym_idx == IdxLast);
   assign w_abort     = w_run && bus.abort;
   assign w_handshake = bus.tx_valid && bus.tx_ready && !w_abort;
   assign w_sample    = w_run && (r_phase == PhMid);

   assign bus.tx_ready   = r_rst_done && (!w_run || w_frame_end);
   assign bus.tx_sym     = r_shift[BITS_PER_SYM-1:0];
   assign bus.busy       = w_run;
   assign bus.sym_strobe = w_run && (r_phase == '0);
   assign bus.phase      = r_phase;
   assign bus.sym_idx    = r_sym_idx;
   assign bus.rx_data    = r_rx_data;
   assign bus.rx_valid   = r_rx_valid;

   // Next-state: handshake, symbol timing, shifting, rx assembly and abort.
   always_comb begin
      w_state_d    = r_state;
      w_phase_d    = r_phase;
      w_sym_idx_d  = r_sym_idx;
      w_shift_d    = r_shift;
      w_rx_asm_d   = r_rx_asm;
      w_rx_data_d  = r_rx_data;
      w_rx_valid_d = 1'b0;

      // Sample is merged before frame end so a mid-point that lands on the last cycle
      // (SPS == 2) still reaches rx_data.
      if (w_sample) begin
         for (int unsigned k = 0; k < NSYM; k++) begin
            if (r_sym_idx == SW'(k)) begin
               w_rx_asm_d[k*BITS_PER_SYM +: BITS_PER_SYM] = w_rx_in;
            end
         end
      end

      if (w_abort) begin
         w_state_d   = StIdle;
         w_phase_d   = '0;
         w_sym_idx_d = '0;
         w_shift_d   = '0;
         w_rx_asm_d  = r_rx_asm;
      end else begin
         if (w_frame_end) begin
            w_rx_data_d  = w_rx_asm_d;
            w_rx_valid_d = 1'b1;
         end
         if (w_handshake) begin
            w_state_d   = StRun;
            w_phase_d   = '0;
            w_sym_idx_d = '0;
            w_shift_d   = bus.tx_data;
         end else if (w_run) begin
            if (r_phase == PhLast) begin
               w_phase_d = '0;
               if (w_frame_end) begin
                  w_state_d   = StIdle;
                  w_sym_idx_d = '0;
                  w_shift_d   = '0;
               end else begin
                  w_sym_idx_d = r_sym_idx + SW'(1);
                  w_shift_d   = r_shift >> BITS_PER_SYM;
               end
            end else begin
               w_phase_d = r_phase + PW'(1);
            end
         end
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge i_clk_sys) begin
      if (i_reset) begin
         r_state    <= StIdle;
         r_phase    <= '0;
         r_sym_idx  <= '0;
         r_shift    <= '0;
         r_rx_asm   <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_rst_done <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_phase    <= w_phase_d;
         r_sym_idx  <= w_sym_idx_d;
         r_shift    <= w_shift_d;
         r_rx_asm   <= w_rx_asm_d;
         r_rx_data  <= w_rx_data_d;
         r_rx_valid <= w_rx_valid_d;
         r_rst_done <= 1'b1;
      end
   end
endmodule

// File: doc/symbol_framer.md
# symbol_framer

Parametrised symbol-timing, serializer and deserializer for the CRC/FSK link. Generates the per-symbol phase and symbol-index timing and shifts a FRAME_BITS-wide CRC word out as BITS_PER_SYM-bit symbols, LSB first. It also reassembles received symbols into a word, sampling each symbol at mid-point. It sits between the CRC generator/checker and the FSK modulator/demodulator. Added over the previous generation: valid/ready frame handshake, gapless back-to-back frames, multi-bit symbols, frame-complete strobe and abort.

## Interface
- SPS, default 256: clk_sys cycles per symbol; must be at least 2.
- FRAME_BITS, default 16: bits per frame (the CRC word width).
- BITS_PER_SYM, default 1: bits per symbol; 2 for 4FSK; must divide FRAME_BITS.
- Derived: NSYM = FRAME_BITS/BITS_PER_SYM; PW = $clog2(SPS); SW = max(1,$clog2(NSYM)).

Ports:
- clk_sys  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  FRAME_BITS  word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  framer accepts tx_data this cycle.
- abort  in  1  drop the current frame and return to IDLE.
- tx_sym  out  BITS_PER_SYM  current symbol to the modulator.
- busy  out  1  frame in progress (RUN state).
- sym_strobe  out  1  first cycle of each symbol (RUN and phase==0).
- phase  out  PW  cycle index within the symbol.
- sym_idx  out  SW  symbol index within the frame.
- rx_sym  in  BITS_PER_SYM  demodulated symbol.
- rx_data  out  FRAME_BITS  last completed received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.

## Operation
- Two states, IDLE and RUN. Reset forces IDLE, phase=0, sym_idx=0, tx shift register=0 (tx_sym=0), rx_data=0, rx_valid=0, busy=0.
- tx_ready = IDLE, or RUN in the last cycle of the frame (phase==SPS-1 and sym_idx==NSYM-1). tx_ready is combinational from state and counters and is never 1 during reset.
- Handshake (tx_valid and tx_ready at an edge):
  - tx_data is loaded into the shift register, phase and sym_idx are set to 0, and the state becomes RUN.
  - tx_data is sampled only at this edge.
- RUN:
  - phase increments each cycle and wraps SPS-1 to 0.
  - On wrap, sym_idx increments and the shift register shifts right by BITS_PER_SYM (zero fill).
  - tx_sym = shift register[BITS_PER_SYM-1:0]. Symbol k therefore carries tx_data[k*BPS +: BPS].
- Frame end (wrap while sym_idx==NSYM-1):
  - If a handshake occurs on the same edge, the next frame starts with no gap.
  - Otherwise the state returns to IDLE, phase and sym_idx return to 0, and tx_sym becomes 0.
- Rx:
  - In RUN, at phase==SPS/2 (integer division), rx_sym is written to the rx assembly register at bits [sym_idx*BPS +: BPS].
  - At frame end, rx_data takes the assembled word and rx_valid pulses for exactly one cycle.
  - rx_data holds between frames.
- abort (priority below reset, above everything else): with the state RUN at an edge, abort forces IDLE and zeroes phase, sym_idx and tx_sym. No rx_valid and no rx_data update occur for that frame. abort in IDLE has no effect; a handshake on the same edge as abort is not accepted.
- Reset mid-frame behaves like abort, and additionally clears rx_data and the rx assembly register.

## Timing
- Handshake at edge E: tx_sym carries symbol 0 and sym_strobe=1 in the cycle after E.
- One frame = NSYM*SPS cycles. rx_valid is high in cycle E+NSYM*SPS (counted as edges after E).
- Back-to-back frames: sym_strobe and symbol 0 of the next frame directly follow the last cycle of the previous frame. busy stays 1 throughout.
- phase, sym_idx, busy, tx_sym and rx_valid are registered. sym_strobe and tx_ready are combinational from registers, with no combinational path from inputs.

## Configuration
- SYMBOL_FRAMER_LOOPBACK_EN defined:
  - Adds input loopback (1 bit).
  - When loopback=1, the rx path samples tx_sym instead of rx_sym.
  - When loopback=0, behaviour is identical to the undefined case.
- Undefined: the loopback port and its mux are absent, and rx always samples rx_sym.

## Test plan
Benches use SPS=4, FRAME_BITS=8, BITS_PER_SYM=2 unless stated otherwise.
- Reset: hold reset for 3 cycles with tx_valid=1. Required: tx_ready=0 and busy=0 during reset; after release, tx_ready=1, rx_data=0, rx_valid=0.
- Single frame, loopback on: tx_data=8'hB4. Required: tx_sym sequence 0,1,3,2, each held 4 cycles; sym_strobe high on phase 0; rx_valid high for one cycle 16 edges after the handshake with rx_data=8'hB4; state then IDLE.
- Back-to-back: send 8'hB4 then 8'h5A with tx_valid held high. Required: second handshake on the last cycle of the first frame, no idle gap, symbols 2,2,1,1 follow directly, rx_valid pulses 16 cycles apart.
- Abort: assert abort at sym_idx=2, phase=1. Required: next cycle busy=0 and tx_sym=0, no rx_valid, rx_data keeps its previous value.
- Default parameters (SPS=256, FRAME_BITS=16, BITS_PER_SYM=1), external rx_sym driven from tx_sym delayed by 10 cycles, tx_data=16'hA5C3. Required: rx_data=16'hA5C3, confirming mid-symbol sampling (sampling at phase 128) tolerates the delay.
- Idle stability: tx_valid=0 for 1000 cycles. Required: phase=0, sym_idx=0, sym_strobe=0, tx_sym=0 throughout.
